// File: rtl/ysyx_22050078_ifetch.sv
//------------------------------------------------------------------------------
// Module   : ysyx_22050078_ifetch
// Purpose  : RV64 fetch front end with one outstanding imem read and a 2-entry
//            {pc, inst} queue toward decode; redirects flush and drop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_22050078_ifetch #(
  parameter int                  PC_WIDTH   = 64,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_inst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [PC_WIDTH-1:0]   out_pc
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [PC_WIDTH-1:0]   r_req_pc;
  logic [1:0]            r_count;
  logic                  r_head;
  logic [PC_WIDTH-1:0]   r_q_pc   [2];
  logic [INST_WIDTH-1:0] r_q_inst [2];

  logic w_req_fire;
  logic w_push;
  logic w_pop;
  logic w_tail;

  // Held low while rst is asserted so no request escapes during reset.
  assign imem_req_valid = !rst && (r_state == ST_RUN) && (r_count != 2'd2);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_push    = (r_state == ST_WAIT) && imem_resp_valid && !redirect_valid;
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign w_tail    = r_head ^ r_count[0];

  assign out_inst = out_valid ? r_q_inst[r_head] : '0;
  assign out_pc   = out_valid ? r_q_pc[r_head]   : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:          if (w_req_fire)      w_state_nxt = ST_WAIT;
      ST_WAIT, ST_DROP: if (imem_resp_valid) w_state_nxt = ST_RUN;
      default:         w_state_nxt = ST_RUN;
    endcase
    // A redirect turns any still-outstanding request into one to be discarded.
    if (redirect_valid && (w_state_nxt != ST_RUN)) begin
      w_state_nxt = ST_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_req_pc <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      end
      if (redirect_valid) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
      end else begin
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        if (w_pop) begin
          r_head <= ~r_head;
        end
      end
    end
  end

  // Storage needs no reset: entries are masked by r_count until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[w_tail]   <= r_req_pc;
      r_q_inst[w_tail] <= imem_resp_inst;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050078_ifetch.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_22050078_ifetch
// Purpose  : Self-checking bench for the fetch front end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_22050078_ifetch;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_inst = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [63:0] out_pc;

  ysyx_22050078_ifetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          ready;
    bit          oready;
    bit          exp_rv;
    logic [63:0] exp_addr;
    bit          exp_ov;
    logic [63:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          due = 0;
  bit          pend = 0;
  logic [63:0] pend_addr = '0;
  logic [63:0] model_pc = A;

  function automatic logic [31:0] mk(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(bit r, bit rd, bit o, bit rv, logic [63:0] a, bit ov, logic [63:0] p);
    vec_t v;
    v = '{r, rd, o, rv, a, ov, p};
    vecs.push_back(v);
  endtask

  // One clock: memory model, PC model and scoreboard act on the pre-edge values.
  task automatic tick();
    bit   fire;
    bit   pop;
    exp_t e;
    fire = imem_req_valid && imem_req_ready;
    pop  = out_valid && out_ready;
    if (pop && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected cyc=%0d actual_pc=%h required=none", cyc, out_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", out_pc, e.pc);
        chk("pop_inst", {32'h0, out_inst}, {32'h0, e.inst});
      end
    end
    if (imem_resp_valid) pend = 0;
    if (fire) begin
      chk("req_addr", imem_req_addr, model_pc);
      pend      = 1;
      pend_addr = imem_req_addr;
      due       = cyc + lat;
    end
    if (redirect_valid) begin
      sb.delete();
      model_pc = {redirect_pc[63:2], 2'b00};
    end else if (fire) begin
      e.pc   = model_pc;
      e.inst = mk(model_pc);
      sb.push_back(e);
      model_pc = model_pc + 64'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = pend && (cyc == due);
    imem_resp_inst  = imem_resp_valid ? mk(pend_addr) : 32'h0;
    redirect_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    out_ready       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_req_addr", imem_req_addr, A);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_inst", {32'h0, out_inst}, 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    rst      = 1'b0;
    cyc      = 0;
    pend     = 0;
    model_pc = A;
    sb.delete();
    #1;
  endtask

  task automatic chk_out(bit rv, logic [63:0] a, bit ov, logic [63:0] p);
    chk("req_valid", {63'h0, imem_req_valid}, {63'h0, rv});
    chk("addr", imem_req_addr, a);
    chk("out_valid", {63'h0, out_valid}, {63'h0, ov});
    chk("out_pc", out_pc, p);
  endtask

  initial begin
    // Steady stream, k=1, decode always ready.
    add(1,1,1, 1,A,      0,0);
    add(0,1,1, 0,A+4,    0,0);
    add(0,1,1, 1,A+4,    1,A);
    add(0,1,1, 0,A+8,    0,0);
    add(0,1,1, 1,A+8,    1,A+4);
    add(0,1,1, 0,A+12,   0,0);
    add(0,1,1, 1,A+12,   1,A+8);
    // Decode stalled: issue stops at count=2, one pop frees a slot.
    add(1,1,0, 1,A,      0,0);
    add(0,1,0, 0,A+4,    0,0);
    add(0,1,0, 1,A+4,    1,A);
    add(0,1,0, 0,A+8,    1,A);
    add(0,1,0, 0,A+8,    1,A);
    add(0,1,1, 0,A+8,    1,A);
    add(0,1,0, 1,A+8,    1,A+4);
    add(0,1,0, 0,A+12,   1,A+4);
    // Memory not ready for 5 cycles: address held.
    add(1,0,1, 1,A,      0,0);
    add(0,0,1, 1,A,      0,0);
    add(0,0,1, 1,A,      0,0);
    add(0,0,1, 1,A,      0,0);
    add(0,0,1, 1,A,      0,0);
    add(0,1,1, 1,A,      0,0);
    add(0,1,1, 0,A+4,    0,0);
    add(0,1,1, 1,A+4,    1,A);

    lat = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      imem_req_ready = vecs[i].ready;
      out_ready      = vecs[i].oready;
      chk_out(vecs[i].exp_rv, vecs[i].exp_addr, vecs[i].exp_ov, vecs[i].exp_pc);
      if (!vecs[i].exp_ov) chk("out_inst_empty", {32'h0, out_inst}, 64'h0);
      tick();
    end

    // Redirect while WAIT: in-flight response dropped.
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
    tick();
    chk("wait_req_valid", {63'h0, imem_req_valid}, 64'h0);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    chk_out(0, 64'h8000_1000, 0, 0);
    tick();
    chk("drop_resp_seen", {63'h0, imem_resp_valid}, 64'h1);
    chk_out(0, 64'h8000_1000, 0, 0);
    tick();
    chk_out(1, 64'h8000_1000, 0, 0);
    lat = 1;
    tick(); tick();
    chk_out(1, 64'h8000_1004, 1, 64'h8000_1000);
    tick();

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick();
    chk("rr_resp", {63'h0, imem_resp_valid}, 64'h1);
    chk_out(0, A+8, 1, A);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; out_ready = 1'b1;
    tick();
    chk_out(1, 64'h8000_1000, 0, 0);
    tick(); tick();
    chk_out(1, 64'h8000_1004, 1, 64'h8000_1000);
    tick();

    // Redirect on a request handshake, misaligned target, PC wrap.
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk_out(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    tick();
    chk_out(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    tick();
    chk_out(0, 64'h0, 0, 0);
    tick();
    chk_out(1, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); tick();
    chk_out(1, 64'h4, 1, 64'h0);

    // Reset while a request is outstanding.
    lat = 5;
    tick();
    chk("pre_rst_wait", {63'h0, imem_req_valid}, 64'h0);
    do_reset();
    chk_out(1, A, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
